// File: rtl/gram_write_arbiter_pkg.sv
// Shared constants and types for the GRam write-port arbiter.
package gram_write_arbiter_pkg;

  localparam int unsigned GRAM_ROW_WORDS = 20;
  localparam int unsigned GRAM_ROWS      = 480;
  localparam int unsigned GRAM_WORDS_DEF = GRAM_ROW_WORDS * GRAM_ROWS;
  localparam int unsigned GRAM_ADDR_W    = 14;
  localparam int unsigned GRAM_DATA_W    = 32;
  localparam logic [31:0] CLEAR_FILL     = 32'h0000_0000;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  // Pointer width for an n-way round-robin; never narrower than one bit.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: scans upward from the last winner, one-hot combinational grant.
module rr_arbiter
  import gram_write_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant
);

  localparam int unsigned PTR_W = ptr_width(NUM_REQ);

  logic [PTR_W-1:0] last_grant;
  logic [PTR_W-1:0] win;
  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    grant = '0;
    win   = last_grant;
    idx   = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = PTR_W'((32'(last_grant) + k) % NUM_REQ);
      if (en && !found && req[idx]) begin
        grant[idx] = 1'b1;
        win        = idx;
        found      = 1'b1;
      end
    end
  end

  // Reset points at the top client so client 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= PTR_W'(NUM_REQ - 1);
    end else if (found) begin
      last_grant <= win;
    end
  end

endmodule

// File: rtl/gram_write_arbiter.sv
// Single GRam write port shared by renderer clients, plus a full-screen clear sequencer.
module gram_write_arbiter
  import gram_write_arbiter_pkg::*;
#(
  parameter int unsigned          NUM_REQ     = 2,
  parameter int unsigned          ADDR_W      = GRAM_ADDR_W,
  parameter int unsigned          DATA_W      = GRAM_DATA_W,
  parameter int unsigned          GRAM_WORDS  = GRAM_WORDS_DEF,
  parameter logic [DATA_W-1:0]    CLEAR_VALUE = DATA_W'(CLEAR_FILL)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        grant,
  input  logic                      clear_start,
  output logic                      clear_busy,
  output logic                      clear_done,
  output logic                      gram_we,
  output logic [ADDR_W-1:0]         gram_addr,
  output logic [DATA_W-1:0]         gram_data
);

  state_e              state;
  state_e              state_nxt;
  logic [ADDR_W-1:0]   count;
  logic [ADDR_W-1:0]   count_nxt;
  logic                arb_en;
  logic                done_c;
  logic                issue_we;
  logic [ADDR_W-1:0]   issue_addr;
  logic [DATA_W-1:0]   issue_data;

  // Arbitration is suppressed on the clear-start cycle, during a clear and in reset.
  assign arb_en     = (state == ST_IDLE) && !clear_start && !rst;
  assign clear_busy = (state == ST_CLEAR);
  assign clear_done = done_c && !rst;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .en    (arb_en),
    .grant (grant)
  );

  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    done_c     = 1'b0;
    issue_we   = 1'b0;
    issue_addr = '0;
    issue_data = '0;
    case (state)
      ST_IDLE: begin
        if (clear_start) begin
          state_nxt = ST_CLEAR;
        end else begin
          for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
              issue_we   = 1'b1;
              issue_addr = req_addr[i*ADDR_W +: ADDR_W];
              issue_data = req_data[i*DATA_W +: DATA_W];
            end
          end
        end
      end
      ST_CLEAR: begin
        issue_we   = 1'b1;
        issue_addr = count;
        issue_data = CLEAR_VALUE;
        if (count == ADDR_W'(GRAM_WORDS - 1)) begin
          done_c    = 1'b1;
          count_nxt = '0;
          state_nxt = ST_IDLE;
        end else begin
          count_nxt = count + ADDR_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Address/data hold their last written value between writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      count     <= '0;
      gram_we   <= 1'b0;
      gram_addr <= '0;
      gram_data <= '0;
    end else begin
      state   <= state_nxt;
      count   <= count_nxt;
      gram_we <= issue_we;
      if (issue_we) begin
        gram_addr <= issue_addr;
        gram_data <= issue_data;
      end
    end
  end

endmodule

// File: tb/tb_gram_write_arbiter.sv
// Bench for gram_write_arbiter: 2-client and 3-client instances against a queue-free cycle model.
module tb_gram_write_arbiter;

  localparam int unsigned AW    = 14;
  localparam int unsigned DW    = 32;
  localparam int          WORDS = 9600;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic clear_start;
  logic clear_start3;

  logic [1:0]      req_a;
  logic [2*AW-1:0] addr_a;
  logic [2*DW-1:0] data_a;
  logic [1:0]      grant_a;
  logic            busy_a, done_a, we_a;
  logic [AW-1:0]   gaddr_a;
  logic [DW-1:0]   gdata_a;

  logic [2:0]      req_b;
  logic [3*AW-1:0] addr_b;
  logic [3*DW-1:0] data_b;
  logic [2:0]      grant_b;
  logic            busy_b, done_b, we_b;
  logic [AW-1:0]   gaddr_b;
  logic [DW-1:0]   gdata_b;

  gram_write_arbiter #(.NUM_REQ(2)) u_dut (
    .clk(clk), .rst(rst), .req(req_a), .req_addr(addr_a), .req_data(data_a),
    .grant(grant_a), .clear_start(clear_start), .clear_busy(busy_a),
    .clear_done(done_a), .gram_we(we_a), .gram_addr(gaddr_a), .gram_data(gdata_a)
  );

  gram_write_arbiter #(.NUM_REQ(3)) u_dut3 (
    .clk(clk), .rst(rst), .req(req_b), .req_addr(addr_b), .req_data(data_b),
    .grant(grant_b), .clear_start(clear_start3), .clear_busy(busy_b),
    .clear_done(done_b), .gram_we(we_b), .gram_addr(gaddr_b), .gram_data(gdata_b)
  );

  // Client behaviour: 0 = drop after grant, 1 = re-present same word, 2 = random.
  logic          c_req  [2][3];
  logic [AW-1:0] c_addr [2][3];
  logic [DW-1:0] c_data [2][3];
  int            c_mode [2][3];

  always_comb begin
    req_a = '0; addr_a = '0; data_a = '0;
    req_b = '0; addr_b = '0; data_b = '0;
    for (int i = 0; i < 2; i++) begin
      req_a[i]             = c_req[0][i];
      addr_a[i*AW +: AW]   = c_addr[0][i];
      data_a[i*DW +: DW]   = c_data[0][i];
    end
    for (int i = 0; i < 3; i++) begin
      req_b[i]             = c_req[1][i];
      addr_b[i*AW +: AW]   = c_addr[1][i];
      data_b[i*DW +: DW]   = c_data[1][i];
    end
  end

  // Reference model state
  int            last     [2];
  int            clr_left;
  logic          exp_we   [2];
  logic [AW-1:0] exp_addr [2];
  logic [DW-1:0] exp_data [2];
  logic          known    [2];
  logic [2:0]    mg       [2];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rr_pick(input int n, input int lst, input logic [2:0] rv);
    for (int k = 1; k <= n; k++) begin
      int idx;
      idx = (lst + k) % n;
      if (rv[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    last[0] = 1; last[1] = 2; clr_left = 0;
    for (int d = 0; d < 2; d++) begin
      exp_we[d] = 1'b0; exp_addr[d] = '0; exp_data[d] = '0; known[d] = 1'b0; mg[d] = '0;
    end
  endtask

  task automatic cycle();
    logic          iss [2];
    logic [AW-1:0] ia  [2];
    logic [DW-1:0] id  [2];
    logic          done_e;
    int            w;
    @(negedge clk);
    check("gram_we", we_a, exp_we[0]);
    if (exp_we[0] || !known[0]) begin
      check("gram_addr", gaddr_a, exp_addr[0]);
      check("gram_data", gdata_a, exp_data[0]);
    end
    check("gram_we3", we_b, exp_we[1]);
    if (exp_we[1] || !known[1]) begin
      check("gram_addr3", gaddr_b, exp_addr[1]);
      check("gram_data3", gdata_b, exp_data[1]);
    end
    for (int d = 0; d < 2; d++) begin
      iss[d] = 1'b0; ia[d] = '0; id[d] = '0; mg[d] = '0;
    end
    if (rst) begin
      check("grant_rst", grant_a, 0);
      check("grant3_rst", grant_b, 0);
      check("done_rst", done_a, 0);
      model_reset();
    end else begin
      check("clear_busy", busy_a, clr_left > 0);
      done_e = 1'b0;
      if (clr_left > 0) begin
        iss[0] = 1'b1;
        ia[0]  = AW'(WORDS - clr_left);
        id[0]  = 32'h0;
        clr_left--;
        done_e = (clr_left == 0);
      end else if (clear_start) begin
        clr_left = WORDS;
      end else begin
        w = rr_pick(2, last[0], {1'b0, c_req[0][1], c_req[0][0]});
        if (w >= 0) begin
          mg[0][w] = 1'b1; last[0] = w;
          iss[0] = 1'b1; ia[0] = c_addr[0][w]; id[0] = c_data[0][w];
        end
      end
      w = rr_pick(3, last[1], {c_req[1][2], c_req[1][1], c_req[1][0]});
      if (w >= 0) begin
        mg[1][w] = 1'b1; last[1] = w;
        iss[1] = 1'b1; ia[1] = c_addr[1][w]; id[1] = c_data[1][w];
      end
      check("grant", grant_a, mg[0][1:0]);
      check("grant3", grant_b, mg[1]);
      check("clear_done", done_a, done_e);
      check("clear_busy3", busy_b, 0);
      for (int d = 0; d < 2; d++) begin
        exp_we[d] = iss[d];
        if (iss[d]) begin
          exp_addr[d] = ia[d]; exp_data[d] = id[d]; known[d] = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    clear_start = 1'b0;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 3; i++) begin
        if (mg[d][i]) begin
          case (c_mode[d][i])
            1:       c_req[d][i] = 1'b1;
            2: begin
              c_req[d][i] = $urandom_range(0, 1) == 1;
              c_addr[d][i] = AW'($urandom);
              c_data[d][i] = $urandom;
            end
            default: c_req[d][i] = 1'b0;
          endcase
        end else if (!c_req[d][i] && c_mode[d][i] == 2 && !(d == 0 && i == 2)) begin
          if ($urandom_range(0, 2) == 0) begin
            c_req[d][i]  = 1'b1;
            c_addr[d][i] = AW'($urandom);
            c_data[d][i] = $urandom;
          end
        end
      end
    end
  endtask

  task automatic all_quiet();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 3; i++) begin
        c_req[d][i] = 1'b0; c_mode[d][i] = 0; c_addr[d][i] = '0; c_data[d][i] = '0;
      end
  endtask

  task automatic set_client(input int d, input int i, input int mode,
                            input logic [AW-1:0] a, input logic [DW-1:0] dat);
    c_req[d][i] = 1'b1; c_mode[d][i] = mode; c_addr[d][i] = a; c_data[d][i] = dat;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clear_start = 1'b0; clear_start3 = 1'b0;
    all_quiet();
    model_reset();
    repeat (3) cycle();
    rst = 1'b0;
    repeat (10) cycle();

    // Single write from client 0
    set_client(0, 0, 0, 14'd806, 32'hF0F0_0000);
    repeat (4) cycle();

    // Continuous contention, both instances
    pulse_reset();
    set_client(0, 0, 1, 14'd100, 32'h0000_0100);
    set_client(0, 1, 1, 14'd200, 32'h0000_0200);
    set_client(1, 0, 1, 14'd100, 32'h1111_1111);
    set_client(1, 1, 1, 14'd200, 32'h2222_2222);
    set_client(1, 2, 1, 14'd300, 32'h3333_3333);
    repeat (4) cycle();
    c_req[1][1] = 1'b0; c_mode[1][1] = 0;
    repeat (4) cycle();
    all_quiet();
    repeat (2) cycle();

    // Clear with client 1 stalled; second clear_start mid-clear ignored
    set_client(0, 1, 0, 14'd16383, 32'hA5A5_5A5A);
    clear_start = 1'b1;
    cycle();
    repeat (50) cycle();
    clear_start = 1'b1;
    repeat (WORDS + 5) cycle();

    // Reset abandons a clear, then a fresh clear starts from 0
    clear_start = 1'b1;
    cycle();
    repeat (3000) cycle();
    pulse_reset();
    repeat (3) cycle();
    clear_start = 1'b1;
    cycle();
    repeat (WORDS + 3) cycle();

    // Random traffic with occasional reset
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 3; i++) c_mode[d][i] = 2;
    c_mode[0][2] = 0;
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 499) == 0) pulse_reset();
      else cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
